// File: rtl/spi_mport.sv
// spi_mport: multi-device SPI master with per-request device select,
// transfer length and clock polarity. One transfer in flight at a time,
// start/ready/done handshake on the host side.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | ready high, waiting for start
// S_LEAD  | CS asserted, SCK idle, first SDI bit presented (GAP cycles)
// S_SHIFT | n bits, HALF cycles at idle level then HALF at active level
// S_TAIL  | CS hold after the last trailing edge (GAP cycles)
// S_RECOV | CS all high recovery before accepting again (GAP cycles)

module spi_mport #(
    parameter int NCS  = 4,
    parameter int CSW  = 2,
    parameter int DW   = 32,
    parameter int NBW  = 6,
    parameter int HALF = 4,
    parameter int GAP  = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    output logic           ready_o,
    input  logic [CSW-1:0] cs_sel_i,
    input  logic [NBW-1:0] nbits_i,
    input  logic           cpol_i,
    input  logic [DW-1:0]  wdata_i,
    output logic [DW-1:0]  rdata_o,
    output logic           done_o,
    output logic           sck_o,
    output logic           sdi_o,
    output logic [NCS-1:0] cs_o,
    input  logic [NCS-1:0] sdo_i
);

    localparam int CNT_MAX = (HALF > GAP) ? HALF : GAP;
    localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_SHIFT,
        S_TAIL,
        S_RECOV
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [NBW-1:0] bits_q;
    logic           half_q;
    logic           cpol_q;
    logic [CSW-1:0] sel_q;
    logic [DW-1:0]  tx_q;
    logic [DW-1:0]  rx_q;
    logic [DW-1:0]  rdata_q;
    logic           done_q;
    logic           ready_q;
    logic           sck_q;
    logic [NCS-1:0] cs_q;

    logic [NBW-1:0] nbits_d;
    logic [NCS-1:0] cs_d;
    logic           sdo_d;

    // Request decode: clamp the length, build the active-low select and
    // pick the return line of the latched device (0 for a nonexistent one).
    always_comb begin
        nbits_d = (nbits_i > NBW'(DW)) ? NBW'(DW) : nbits_i;
        cs_d    = '1;
        sdo_d   = 1'b0;
        for (int i = 0; i < NCS; i++) begin
            if (cs_sel_i == CSW'(i)) cs_d[i] = 1'b0;
            if (sel_q == CSW'(i))    sdo_d   = sdo_i[i];
        end
    end

    // Sequencer: all pin-facing outputs are registered here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bits_q  <= '0;
            half_q  <= 1'b0;
            cpol_q  <= 1'b0;
            sel_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            sck_q   <= 1'b0;
            cs_q    <= '1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_LEAD;
                        ready_q <= 1'b0;
                        sel_q   <= cs_sel_i;
                        cpol_q  <= cpol_i;
                        sck_q   <= cpol_i;
                        bits_q  <= nbits_d;
                        // Left-justify so the first bit sits at the MSB;
                        // a zero length shifts everything out.
                        tx_q    <= wdata_i << (DW - int'(nbits_d));
                        rx_q    <= '0;
                        cs_q    <= cs_d;
                        cnt_q   <= CW'(GAP - 1);
                    end
                end
                S_LEAD: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (bits_q == '0) begin
                        state_q <= S_TAIL;
                        cnt_q   <= CW'(GAP - 1);
                    end else begin
                        state_q <= S_SHIFT;
                        half_q  <= 1'b0;
                        cnt_q   <= CW'(HALF - 1);
                    end
                end
                S_SHIFT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (!half_q) begin
                        // Leading edge: capture the device bit.
                        sck_q  <= ~cpol_q;
                        rx_q   <= {rx_q[DW-2:0], sdo_d};
                        half_q <= 1'b1;
                        cnt_q  <= CW'(HALF - 1);
                    end else begin
                        // Trailing edge: advance SDI to the next bit.
                        sck_q  <= cpol_q;
                        tx_q   <= tx_q << 1;
                        half_q <= 1'b0;
                        bits_q <= bits_q - 1'b1;
                        if (bits_q == NBW'(1)) begin
                            state_q <= S_TAIL;
                            cnt_q   <= CW'(GAP - 1);
                        end else begin
                            cnt_q   <= CW'(HALF - 1);
                        end
                    end
                end
                S_TAIL: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= S_RECOV;
                        cs_q    <= '1;
                        done_q  <= 1'b1;
                        rdata_q <= rx_q;
                        cnt_q   <= CW'(GAP - 1);
                    end
                end
                S_RECOV: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    cs_q    <= '1;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign done_o  = done_q;
    assign rdata_o = rdata_q;
    assign sck_o   = sck_q;
    assign sdi_o   = tx_q[DW-1];
    assign cs_o    = cs_q;

endmodule
